// File: rtl/reaction_timer.sv
// Start-lights reaction timer: counts 1 ms ticks from lights-out to the player's
// press and reports the result as 4-digit BCD, flagging jump starts and overflow.
module reaction_timer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MS      = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        seq_start,
  input  logic        lights_out,
  input  logic        button,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        jump_start,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StArmed  = 5'b00010,
    StTiming = 5'b00100,
    StDone   = 5'b01000,
    StJump   = 5'b10000
  } state_e;

  function automatic logic [15:0] to_bcd(int unsigned v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Digit-wise increment; a digit at 9 wraps to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [15:0] MaxBcd = to_bcd(MAX_MS);

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   press_q;
  logic [15:0]            bcd_q;
  logic                   valid_q;
  logic                   jump_q;
  logic                   ovf_q;
  logic                   busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], button};
      prev_q  <= sync_q[SYNC_STAGES-1];
      press_q <= sync_q[SYNC_STAGES-1] & ~prev_q;

      // A new light sequence overrides everything else in the same cycle.
      if (seq_start) begin
        state_q <= StArmed;
        bcd_q   <= '0;
        valid_q <= 1'b0;
        jump_q  <= 1'b0;
        ovf_q   <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StArmed: begin
            if (press_q) begin
              state_q <= StJump;
              jump_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (lights_out) begin
              state_q <= StTiming;
            end
          end
          StTiming: begin
            if (press_q) begin
              state_q <= StDone;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (tick && (bcd_q != MaxBcd)) begin
              bcd_q <= bcd_inc(bcd_q);
              if (bcd_inc(bcd_q) == MaxBcd) ovf_q <= 1'b1;
            end
          end
          StIdle, StDone, StJump: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bcd        = bcd_q;
  assign valid      = valid_q;
  assign jump_start = jump_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with hand-computed expectations.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        seq_start = 1'b0;
  logic        lights_out = 1'b0;
  logic        button = 1'b0;
  logic [15:0] bcd;
  logic        valid;
  logic        jump_start;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  reaction_timer #(
    .SYNC_STAGES(2),
    .MAX_MS     (9999)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .seq_start (seq_start),
    .lights_out(lights_out),
    .button    (button),
    .bcd       (bcd),
    .valid     (valid),
    .jump_start(jump_start),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    cyc(n);
    tick = 1'b0;
  endtask

  task automatic pulse_seq();
    seq_start = 1'b1;
    cyc(1);
    seq_start = 1'b0;
  endtask

  task automatic pulse_lo();
    lights_out = 1'b1;
    cyc(1);
    lights_out = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic v, input logic j, input logic o,
                           input logic b);
    chk({tag, ".valid"}, {15'd0, valid}, {15'd0, v});
    chk({tag, ".jump"}, {15'd0, jump_start}, {15'd0, j});
    chk({tag, ".ovf"}, {15'd0, overflow}, {15'd0, o});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
  endtask

  initial begin
    // Reset
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst.bcd", bcd, 16'h0000);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: 237 ms reaction, press latency is exactly 4 cycles
    pulse_seq();
    chk_flags("t1.armed", 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_lo();
    ticks(237);
    chk("t1.count", bcd, 16'h0237);
    button = 1'b1;
    cyc(3);
    chk("t1.early", {15'd0, valid}, 16'h0000);
    cyc(1);
    chk("t1.bcd", bcd, 16'h0237);
    chk_flags("t1.done", 1'b1, 1'b0, 1'b0, 1'b0);
    button = 1'b0;
    cyc(3);

    // 2: jump start; later lights_out ignored
    pulse_seq();
    chk("t2.clr", bcd, 16'h0000);
    chk_flags("t2.armed", 1'b0, 1'b0, 1'b0, 1'b1);
    button = 1'b1;
    cyc(4);
    chk("t2.bcd", bcd, 16'h0000);
    chk_flags("t2.jump", 1'b0, 1'b1, 1'b0, 1'b0);
    button = 1'b0;
    cyc(3);
    pulse_lo();
    ticks(5);
    chk("t2.after.bcd", bcd, 16'h0000);
    chk_flags("t2.after", 1'b0, 1'b1, 1'b0, 1'b0);

    // 4: carry chain, and a tick coinciding with press is dropped
    pulse_seq();
    pulse_lo();
    ticks(99);
    chk("t4.99", bcd, 16'h0099);
    ticks(900);
    chk("t4.999", bcd, 16'h0999);
    ticks(100);
    chk("t4.1099", bcd, 16'h1099);
    button = 1'b1;
    tick   = 1'b1;
    cyc(4);
    tick = 1'b0;
    chk("t4.coinc", bcd, 16'h1102);
    chk_flags("t4.done", 1'b1, 1'b0, 1'b0, 1'b0);
    button = 1'b0;
    cyc(3);

    // 3: saturation
    pulse_seq();
    pulse_lo();
    ticks(9998);
    chk("t3.9998", bcd, 16'h9998);
    chk("t3.noovf", {15'd0, overflow}, 16'h0000);
    ticks(1);
    chk("t3.9999", bcd, 16'h9999);
    chk("t3.ovf", {15'd0, overflow}, 16'h0001);
    ticks(6);
    chk("t3.hold", bcd, 16'h9999);
    chk_flags("t3.timing", 1'b0, 1'b0, 1'b1, 1'b1);
    button = 1'b1;
    cyc(4);
    chk("t3.bcd", bcd, 16'h9999);
    chk_flags("t3.done", 1'b1, 1'b0, 1'b1, 1'b0);
    button = 1'b0;
    cyc(3);

    // 5: held button gives one press; 1-cycle glitch gives one press
    pulse_seq();
    pulse_lo();
    button = 1'b1;
    cyc(4);
    chk_flags("t5.first", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_seq();
    cyc(10);
    chk_flags("t5.held", 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_lo();
    ticks(500);
    chk("t5.500", bcd, 16'h0500);
    chk_flags("t5.timing", 1'b0, 1'b0, 1'b0, 1'b1);
    button = 1'b0;
    cyc(3);
    button = 1'b1;
    cyc(1);
    button = 1'b0;
    cyc(5);
    chk("t5.glitch.bcd", bcd, 16'h0500);
    chk_flags("t5.glitch", 1'b1, 1'b0, 1'b0, 1'b0);
    // press coinciding with lights_out
    pulse_seq();
    button = 1'b1;
    cyc(3);
    lights_out = 1'b1;
    cyc(1);
    lights_out = 1'b0;
    chk_flags("t5.coinc", 1'b0, 1'b1, 1'b0, 1'b0);
    button = 1'b0;
    cyc(3);

    // 6: reset during timing, then seq_start from DONE
    pulse_seq();
    pulse_lo();
    ticks(50);
    chk("t6.50", bcd, 16'h0050);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6.rst.bcd", bcd, 16'h0000);
    chk_flags("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    chk("t6.idle.bcd", bcd, 16'h0000);
    pulse_seq();
    pulse_lo();
    ticks(7);
    button = 1'b1;
    cyc(4);
    button = 1'b0;
    chk("t6.done.bcd", bcd, 16'h0007);
    chk_flags("t6.done", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_seq();
    chk("t6.rearm.bcd", bcd, 16'h0000);
    chk_flags("t6.rearm", 1'b0, 1'b0, 1'b0, 1'b1);
    // seq_start beats a coincident tick while timing
    pulse_lo();
    ticks(4);
    seq_start = 1'b1;
    tick      = 1'b1;
    cyc(1);
    seq_start = 1'b0;
    tick      = 1'b0;
    chk("t6.prio.bcd", bcd, 16'h0000);
    chk_flags("t6.prio", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
